// File: rtl/ah_snoop_fifo_param_if.sv
// ah_snoop_fifo_param_if: write/read/snoop bundle for the snoopable FIFO
interface ah_snoop_fifo_param_if #(
  parameter int WIDTH = 40,
  parameter int KEY_W = 3,
  parameter int AW = 7
);
  logic [WIDTH-1:0] wdata;
  logic wvalid;
  logic wready;
  logic [WIDTH-1:0] rdata;
  logic rvalid;
  logic rready;
  logic [KEY_W-1:0] sdata;
  logic svalid;
  logic smatch;
  logic [AW:0] smatch_cnt;
  logic [AW:0] count;
  modport master (
    output wdata, wvalid, rready, sdata, svalid,
    input wready, rdata, rvalid, smatch, smatch_cnt, count
  );
  modport slave (
    input wdata, wvalid, rready, sdata, svalid,
    output wready, rdata, rvalid, smatch, smatch_cnt, count
  );
endinterface

// File: rtl/ah_snoop_fifo_param.sv
// ah_snoop_fifo_param: FWFT valid/ready FIFO with a one-cycle registered key snoop over occupied entries
module ah_snoop_fifo_param #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 78,
  parameter int KEY_W = 3,
  parameter int KEY_LSB = 0,
  parameter int WR_FWD = 1
) (
  input logic clk,
  input logic rstn,
  ah_snoop_fifo_param_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW-1:0] wr_idx, rd_idx;
  logic empty, full, push, pop, same_phase;
  int unsigned hits;
  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign same_phase = wr_ptr[AW] == rd_ptr[AW];
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_idx == rd_idx && !same_phase;
  assign push = s.wvalid && !full;
  assign pop = s.rready && !empty;
  assign s.wready = !full;
  assign s.rvalid = !empty;
  assign s.rdata = empty ? '0 : mem[rd_idx];
  assign s.count = same_phase ? {1'b0, wr_idx} - {1'b0, rd_idx}
                              : (AW+1)'(DEPTH) + {1'b0, wr_idx} - {1'b0, rd_idx};
  // index wraps at DEPTH-1, not at a power of two, so the phase bit flips explicitly
  function automatic logic [AW:0] inc(input logic [AW:0] p);
    return (p[AW-1:0] == AW'(DEPTH - 1)) ? {~p[AW], {AW{1'b0}}} : p + (AW+1)'(1);
  endfunction
  always_comb begin
    hits = 0;
    for (int e = 0; e < DEPTH; e++)
      if (same_phase ? (AW'(e) >= rd_idx && AW'(e) < wr_idx) : (AW'(e) >= rd_idx || AW'(e) < wr_idx))
        hits += 32'(mem[e][KEY_LSB +: KEY_W] == s.sdata);
    if (WR_FWD != 0 && push && s.wdata[KEY_LSB +: KEY_W] == s.sdata)
      hits += 1;
  end
  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      s.smatch <= 1'b0;
      s.smatch_cnt <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      s.smatch <= s.svalid && hits != 0;
      s.smatch_cnt <= s.svalid ? (AW+1)'(hits > 32'(DEPTH) ? 32'(DEPTH) : hits) : '0;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_idx] <= s.wdata;
endmodule

// File: tb/tb_ah_snoop_fifo_param.sv
// tb_ah_snoop_fifo_param: random and directed stimulus against a queue model, two parameter sets
module tb_ah_snoop_fifo_param;
  localparam int D = 78;
  localparam int DS = 5;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic rstn_b = 1'b1;
  always #5 clk = ~clk;
  ah_snoop_fifo_param_if #(.WIDTH(40), .KEY_W(3), .AW(7)) a();
  ah_snoop_fifo_param_if #(.WIDTH(8), .KEY_W(4), .AW(3)) b();
  ah_snoop_fifo_param #(.WIDTH(40), .DEPTH(78), .KEY_W(3), .KEY_LSB(0), .WR_FWD(1))
    dut (.clk(clk), .rstn(rstn), .s(a));
  ah_snoop_fifo_param #(.WIDTH(8), .DEPTH(5), .KEY_W(4), .KEY_LSB(4), .WR_FWD(0))
    dut_b (.clk(clk), .rstn(rstn_b), .s(b));
  int checks = 0;
  int errors = 0;
  logic [39:0] qa[$];
  logic [7:0] qb[$];
  logic em_a = 1'b0, em_b = 1'b0;
  int ec_a = 0, ec_b = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // model: hits are counted over the queue contents before the edge, then pop/push applied
  task automatic step_a(input logic rst, input logic wv, input logic [39:0] wd, input logic rr,
                        input logic sv, input logic [2:0] sd);
    int n;
    logic ps, pp;
    rstn = rst; a.wvalid = wv; a.wdata = wd; a.rready = rr; a.svalid = sv; a.sdata = sd;
    ps = wv && qa.size() < D;
    pp = rr && qa.size() > 0;
    n = 0;
    foreach (qa[i]) if (qa[i][2:0] == sd) n++;
    if (ps && wd[2:0] == sd) n++;
    @(posedge clk); #1;
    if (rst) begin
      qa.delete(); em_a = 1'b0; ec_a = 0;
    end else begin
      if (pp) void'(qa.pop_front());
      if (ps) qa.push_back(wd);
      em_a = sv && n > 0;
      ec_a = sv ? (n > D ? D : n) : 0;
    end
    chk("a_wready", 64'(a.wready), 64'(qa.size() < D));
    chk("a_rvalid", 64'(a.rvalid), 64'(qa.size() > 0));
    chk("a_rdata", 64'(a.rdata), qa.size() > 0 ? 64'(qa[0]) : 64'(0));
    chk("a_count", 64'(a.count), 64'(qa.size()));
    chk("a_smatch", 64'(a.smatch), 64'(em_a));
    chk("a_smatch_cnt", 64'(a.smatch_cnt), 64'(ec_a));
  endtask
  task automatic step_b(input logic rst, input logic wv, input logic [7:0] wd, input logic rr,
                        input logic sv, input logic [3:0] sd);
    int n;
    logic ps, pp;
    rstn_b = rst; b.wvalid = wv; b.wdata = wd; b.rready = rr; b.svalid = sv; b.sdata = sd;
    ps = wv && qb.size() < DS;
    pp = rr && qb.size() > 0;
    n = 0;
    foreach (qb[i]) if (qb[i][7:4] == sd) n++;
    @(posedge clk); #1;
    if (rst) begin
      qb.delete(); em_b = 1'b0; ec_b = 0;
    end else begin
      if (pp) void'(qb.pop_front());
      if (ps) qb.push_back(wd);
      em_b = sv && n > 0;
      ec_b = sv ? n : 0;
    end
    chk("b_wready", 64'(b.wready), 64'(qb.size() < DS));
    chk("b_rvalid", 64'(b.rvalid), 64'(qb.size() > 0));
    chk("b_rdata", 64'(b.rdata), qb.size() > 0 ? 64'(qb[0]) : 64'(0));
    chk("b_count", 64'(b.count), 64'(qb.size()));
    chk("b_smatch", 64'(b.smatch), 64'(em_b));
    chk("b_smatch_cnt", 64'(b.smatch_cnt), 64'(ec_b));
  endtask
  function automatic logic [39:0] rword(input logic [2:0] key);
    return {32'($urandom), 5'($urandom), key};
  endfunction
  task automatic push_a(input int n);
    for (int i = 0; i < n; i++) step_a(0, 1, rword(3'($urandom)), 0, 1'($urandom), 3'($urandom));
  endtask
  task automatic pop_a(input int n);
    for (int i = 0; i < n; i++) step_a(0, 0, '0, 1, 1'($urandom), 3'($urandom));
  endtask
  initial begin
    a.wvalid = 0; a.wdata = '0; a.rready = 0; a.svalid = 0; a.sdata = '0;
    b.wvalid = 0; b.wdata = '0; b.rready = 0; b.svalid = 0; b.sdata = '0;
    repeat (2) step_a(1, 0, '0, 0, 0, '0);
    for (int i = 0; i < 79; i++) step_a(0, 1, 40'(i), 0, 1'($urandom), 3'($urandom));
    chk("t1_full_wready", 64'(a.wready), 64'(0));
    chk("t1_full_count", 64'(a.count), 64'(78));
    for (int i = 0; i < 78; i++) begin
      chk("t1_order", 64'(a.rdata), 64'(i));
      step_a(0, 0, '0, 1, 1'($urandom), 3'($urandom));
    end
    step_a(0, 0, '0, 1, 0, '0);
    chk("t1_empty_rdata", 64'(a.rdata), 64'(0));
    push_a(50); pop_a(50); push_a(60); pop_a(60);
    chk("t2_count", 64'(a.count), 64'(0));
    push_a(78);
    step_a(0, 1, rword(3'd0), 1, 0, '0);
    chk("t3_full_pop_only", 64'(a.count), 64'(77));
    pop_a(72);
    step_a(0, 1, rword(3'd6), 1, 0, '0);
    chk("t3_push_pop_count", 64'(a.count), 64'(5));
    pop_a(6);
    for (int i = 0; i < 3; i++) step_a(0, 1, rword(3'd1), 0, 0, '0);
    pop_a(3);
    foreach (qa[i]) chk("t4_drained", 64'(qa.size()), 64'(0));
    step_a(0, 1, rword(3'd1), 0, 0, '0);
    step_a(0, 1, rword(3'd2), 0, 0, '0);
    step_a(0, 1, rword(3'd1), 0, 0, '0);
    step_a(0, 1, rword(3'd5), 0, 0, '0);
    step_a(0, 0, '0, 0, 1, 3'd1);
    chk("t4_hit", 64'(a.smatch), 64'(1));
    chk("t4_hit_cnt", 64'(a.smatch_cnt), 64'(2));
    step_a(0, 0, '0, 0, 1, 3'd7);
    chk("t4_miss_cnt", 64'(a.smatch_cnt), 64'(0));
    step_a(0, 1, rword(3'd1), 1, 1, 3'd1);
    chk("t5_fwd_cnt", 64'(a.smatch_cnt), 64'(3));
    for (int i = 0; i < 3000; i++)
      step_a(0, $urandom_range(0, 9) < (i < 1500 ? 6 : 4), rword(3'($urandom)),
             $urandom_range(0, 9) < (i < 1500 ? 4 : 6), 1'($urandom), 3'($urandom));
    pop_a(D + 1);
    push_a(40);
    step_a(0, 0, '0, 0, 1, qa[0][2:0]);
    chk("t6_pre_hit", 64'(a.smatch), 64'(1));
    step_a(1, 1, rword(3'd2), 1, 1, qa[1][2:0]);
    chk("t6_count", 64'(a.count), 64'(0));
    chk("t6_rvalid", 64'(a.rvalid), 64'(0));
    chk("t6_smatch", 64'(a.smatch), 64'(0));
    push_a(10); pop_a(11);
    rstn = 1'b1;
    repeat (2) step_b(1, 0, '0, 0, 0, '0);
    for (int i = 0; i < 6; i++) step_b(0, 1, 8'(i), 0, 1'($urandom), 4'($urandom));
    chk("b_t1_full_count", 64'(b.count), 64'(5));
    chk("b_t1_full_wready", 64'(b.wready), 64'(0));
    for (int i = 0; i < 5; i++) begin
      chk("b_t1_order", 64'(b.rdata), 64'(i));
      step_b(0, 0, '0, 1, 1'($urandom), 4'($urandom));
    end
    step_b(0, 0, '0, 1, 0, '0);
    chk("b_t1_empty_rvalid", 64'(b.rvalid), 64'(0));
    step_b(0, 1, {4'd1, 4'($urandom)}, 0, 0, '0);
    step_b(0, 1, {4'd2, 4'($urandom)}, 0, 0, '0);
    step_b(0, 1, {4'd1, 4'($urandom)}, 0, 0, '0);
    step_b(0, 1, {4'd5, 4'($urandom)}, 0, 0, '0);
    step_b(0, 1, {4'd1, 4'h3}, 1, 1, 4'd1);
    chk("b_t5_nofwd_cnt", 64'(b.smatch_cnt), 64'(2));
    for (int i = 0; i < 800; i++)
      step_b(0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
